// File: rtl/mx_alu_instr_decoder.sv
// rtl/mx_alu_instr_decoder.sv - MX ALU instruction decoder and per-beat micro-op issuer
//
// Purpose: accepts 32-bit MX ALU instruction words, rejects illegal op/dtype
// encodings and expands each legal instruction into nblk * beats micro-ops.
// Ports:
//   clk, rst                        clock (rising edge), async active-high reset
//   instr_valid/instr_ready/instr_data  instruction input handshake
//   uop_valid/uop_ready             micro-op output handshake
//   uop_op, uop_dtype, uop_rd/rs1/rs2   decoded fields (rs2 = 0 for unary ops)
//   uop_block_idx, uop_beat_idx     position of the current micro-op
//   uop_first, uop_last             first / last micro-op of the instruction
//   err_illegal, err_code           illegal-drop pulse and sticky cause
//   busy                            issue in progress
module mx_alu_instr_decoder #(
  parameter int BLOCK_SIZE = 32,
  parameter int DATAPATH_W = 64,
  parameter int REG_AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr_data,
  output logic              uop_valid,
  input  logic              uop_ready,
  output logic [3:0]        uop_op,
  output logic [2:0]        uop_dtype,
  output logic [REG_AW-1:0] uop_rd,
  output logic [REG_AW-1:0] uop_rs1,
  output logic [REG_AW-1:0] uop_rs2,
  output logic [9:0]        uop_block_idx,
  output logic [2:0]        uop_beat_idx,
  output logic              uop_first,
  output logic              uop_last,
  output logic              err_illegal,
  output logic [1:0]        err_code,
  output logic              busy
);

  // Beats per block for each element width, rounded up.
  localparam int BEATS_8 = (BLOCK_SIZE * 8 + DATAPATH_W - 1) / DATAPATH_W;
  localparam int BEATS_6 = (BLOCK_SIZE * 6 + DATAPATH_W - 1) / DATAPATH_W;
  localparam int BEATS_4 = (BLOCK_SIZE * 4 + DATAPATH_W - 1) / DATAPATH_W;
  localparam logic [2:0] BM1_8 = 3'(BEATS_8 - 1);
  localparam logic [2:0] BM1_6 = 3'(BEATS_6 - 1);
  localparam logic [2:0] BM1_4 = 3'(BEATS_4 - 1);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;
  state_t state, state_nxt;

  logic [3:0] d_op;
  logic [2:0] d_dtype;
  logic       op_bad, dtype_bad, pair_bad, illegal;
  logic [1:0] d_code;
  logic [2:0] d_beats_m1;
  logic       accept, uop_hs, last_hit;
  logic [9:0] nblk_m1;
  logic [2:0] beats_m1;

  assign d_op    = instr_data[3:0];
  assign d_dtype = instr_data[6:4];

  always_comb begin
    op_bad    = d_op > 4'd10;
    dtype_bad = d_dtype > 3'd5;
    // EXP and DIV have no integer implementation.
    pair_bad  = (d_dtype == 3'd0) && ((d_op == 4'd3) || (d_op == 4'd9));
    illegal   = op_bad || dtype_bad || pair_bad;
    if (op_bad)         d_code = 2'd1;
    else if (dtype_bad) d_code = 2'd2;
    else                d_code = 2'd3;
    case (d_dtype)
      3'd0, 3'd1, 3'd2: d_beats_m1 = BM1_8;
      3'd3, 3'd4:       d_beats_m1 = BM1_6;
      default:          d_beats_m1 = BM1_4;
    endcase
  end

  assign accept   = instr_valid && instr_ready;
  assign uop_hs   = uop_valid && uop_ready;
  assign last_hit = (uop_block_idx == nblk_m1) && (uop_beat_idx == beats_m1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !illegal) state_nxt = ISSUE;
      ISSUE:   if (uop_hs && last_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    instr_ready = (state == IDLE);
    uop_valid   = (state == ISSUE);
    busy        = (state != IDLE);
  end

  // first/last are masked so they read 0 whenever no micro-op is presented.
  assign uop_first = uop_valid && (uop_block_idx == 10'd0) && (uop_beat_idx == 3'd0);
  assign uop_last  = uop_valid && last_hit;

  // Latched fields and block/beat counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uop_op        <= '0;
      uop_dtype     <= '0;
      uop_rd        <= '0;
      uop_rs1       <= '0;
      uop_rs2       <= '0;
      uop_block_idx <= '0;
      uop_beat_idx  <= '0;
      nblk_m1       <= '0;
      beats_m1      <= '0;
      err_illegal   <= 1'b0;
      err_code      <= '0;
    end else begin
      err_illegal <= 1'b0;
      if (accept) begin
        if (illegal) begin
          err_illegal <= 1'b1;
          err_code    <= d_code;
        end else begin
          uop_op        <= d_op;
          uop_dtype     <= d_dtype;
          uop_rd        <= REG_AW'(instr_data[11:7]);
          uop_rs1       <= REG_AW'(instr_data[16:12]);
          // Only binary ops (6..10) read a second source.
          uop_rs2       <= (d_op >= 4'd6) ? REG_AW'(instr_data[21:17]) : '0;
          nblk_m1       <= instr_data[31:22];
          beats_m1      <= d_beats_m1;
          uop_block_idx <= '0;
          uop_beat_idx  <= '0;
        end
      end else if (uop_hs && !last_hit) begin
        if (uop_beat_idx == beats_m1) begin
          uop_beat_idx  <= '0;
          uop_block_idx <= uop_block_idx + 10'd1;
        end else begin
          uop_beat_idx <= uop_beat_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mx_alu_instr_decoder.sv
// tb/tb_mx_alu_instr_decoder.sv - self-checking bench for mx_alu_instr_decoder
module tb_mx_alu_instr_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr_data = '0;
  logic        uop_valid;
  logic        uop_ready = 1'b1;
  logic [3:0]  uop_op;
  logic [2:0]  uop_dtype;
  logic [4:0]  uop_rd, uop_rs1, uop_rs2;
  logic [9:0]  uop_block_idx;
  logic [2:0]  uop_beat_idx;
  logic        uop_first, uop_last;
  logic        err_illegal;
  logic [1:0]  err_code;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mx_alu_instr_decoder dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_op(uop_op), .uop_dtype(uop_dtype),
    .uop_rd(uop_rd), .uop_rs1(uop_rs1), .uop_rs2(uop_rs2),
    .uop_block_idx(uop_block_idx), .uop_beat_idx(uop_beat_idx),
    .uop_first(uop_first), .uop_last(uop_last),
    .err_illegal(err_illegal), .err_code(err_code), .busy(busy)
  );

  typedef struct {
    logic [31:0] instr;
    int          nuops;
    int          bpb;
    bit          err;
    logic [1:0]  code;
    bit          toggle;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [31:0] enc(int op, int dt, int rd, int rs1, int rs2, int nb);
    return {10'(nb), 5'(rs2), 5'(rs1), 5'(rd), 3'(dt), 4'(op)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction and returns one cycle after its handshake.
  task automatic send(input logic [31:0] w);
    int n = 0;
    instr_data  = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 100) begin
      step();
      n++;
    end
    if (!instr_ready) chk("send_timeout", 64'd0, 64'd1);
    step();
    instr_valid = 1'b0;
  endtask

  // Walks the micro-op stream; during stalls the expected value stays on index k,
  // which also verifies that outputs are held stable.
  task automatic collect(input string tag, input logic [31:0] w, input int nuops,
                         input int bpb, input bit toggle);
    int k = 0;
    int cyc = 0;
    logic [3:0] op;
    logic [2:0] dt;
    logic [4:0] rd, rs1, rs2e;
    logic [9:0] eb;
    logic [2:0] et;
    logic [39:0] act, exp;
    op   = w[3:0];
    dt   = w[6:4];
    rd   = w[11:7];
    rs1  = w[16:12];
    rs2e = (op >= 4'd6) ? w[21:17] : 5'd0;
    chk({tag, "_latency"}, {63'd0, uop_valid}, 64'd1);
    while (k < nuops && cyc < nuops * 3 + 20) begin
      uop_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      eb  = 10'(k / bpb);
      et  = 3'(k % bpb);
      exp = {1'b1, 1'b0, 1'b1, op, dt, rd, rs1, rs2e, eb, et, (k == 0), (k == nuops - 1)};
      act = {uop_valid, instr_ready, busy, uop_op, uop_dtype, uop_rd, uop_rs1, uop_rs2,
             uop_block_idx, uop_beat_idx, uop_first, uop_last};
      chk($sformatf("%s_uop%0d", tag, k), {24'd0, act}, {24'd0, exp});
      if (uop_valid && uop_ready) k++;
      step();
      cyc++;
    end
    if (k < nuops) chk({tag, "_timeout"}, 64'(k), 64'(nuops));
    uop_ready = 1'b1;
    chk({tag, "_done"}, {61'd0, uop_valid, instr_ready, busy}, {61'd0, 3'b010});
  endtask

  initial begin
    vecs[0]  = '{enc(6, 2, 3, 1, 2, 0),    4,    4, 1'b0, 2'd0, 1'b0}; // ADD E4M3
    vecs[1]  = '{enc(1, 5, 4, 5, 7, 2),    6,    2, 1'b0, 2'd0, 1'b0}; // SUM E2M1, rs2 dropped
    vecs[2]  = '{enc(3, 0, 1, 1, 1, 0),    0,    0, 1'b1, 2'd3, 1'b0}; // EXP MXINT8
    vecs[3]  = '{enc(12, 1, 1, 1, 1, 0),   0,    0, 1'b1, 2'd1, 1'b0}; // bad op
    vecs[4]  = '{enc(6, 7, 1, 1, 1, 0),    0,    0, 1'b1, 2'd2, 1'b0}; // bad dtype
    vecs[5]  = '{enc(13, 7, 1, 1, 1, 0),   0,    0, 1'b1, 2'd1, 1'b0}; // op beats dtype
    vecs[6]  = '{enc(9, 0, 2, 2, 2, 0),    0,    0, 1'b1, 2'd3, 1'b0}; // DIV MXINT8
    vecs[7]  = '{enc(8, 3, 9, 10, 11, 0),  3,    3, 1'b0, 2'd0, 1'b1}; // MUL E3M2 stalled
    vecs[8]  = '{enc(2, 4, 6, 7, 8, 1),    6,    3, 1'b0, 2'd0, 1'b0}; // NEG E2M3
    vecs[9]  = '{enc(0, 0, 31, 30, 29, 0), 4,    4, 1'b0, 2'd0, 1'b0}; // BC MXINT8
    vecs[10] = '{enc(10, 1, 17, 18, 19, 1023), 4096, 4, 1'b0, 2'd0, 1'b0}; // DOT max blocks

    // Reset state
    step();
    step();
    chk("reset_outputs",
        {24'd0, uop_valid, busy, err_illegal, err_code, uop_op, uop_dtype, uop_rd, uop_rs1,
         uop_rs2, uop_block_idx, uop_beat_idx, uop_first, uop_last},
        64'd0);
    rst = 1'b0;
    step();
    chk("reset_ready", {63'd0, instr_ready}, 64'd1);

    for (int i = 0; i < 11; i++) begin
      send(vecs[i].instr);
      if (vecs[i].err) begin
        chk($sformatf("v%0d_err_pulse", i), {59'd0, err_illegal, err_code, uop_valid, busy},
            {59'd0, 1'b1, vecs[i].code, 2'b00});
        step();
        chk($sformatf("v%0d_err_hold", i), {59'd0, err_illegal, err_code, uop_valid, busy},
            {59'd0, 1'b0, vecs[i].code, 2'b00});
      end else begin
        collect($sformatf("v%0d", i), vecs[i].instr, vecs[i].nuops, vecs[i].bpb, vecs[i].toggle);
      end
    end

    // Reset in the middle of issuing beat 2 of 4
    send(enc(6, 2, 3, 1, 2, 0));
    step();
    step();
    chk("mid_beat2", {61'd0, uop_beat_idx}, 64'd2);
    rst = 1'b1;
    #1;
    chk("mid_reset", {48'd0, uop_valid, busy, err_code, uop_beat_idx, uop_rd, uop_op},
        64'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_reset_ready", {62'd0, instr_ready, busy}, 64'd2);
    send(enc(7, 5, 12, 13, 14, 0));
    collect("post_reset", enc(7, 5, 12, 13, 14, 0), 2, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
